// File: rtl/gcd_dispatch.sv
// gcd_dispatch
//   Feeds operand pairs to a gcd core one at a time and returns each result
//   in arrival order.
//   - Incoming pairs are buffered in a small FIFO.
//   - A one-cycle gcd_enable launches the core.
//   - gcd_a/gcd_b stay stable until the core answers.
//   - Each result is presented together with its operands.
//
// Ports
//   clk, reset             single rising-edge clock, synchronous active-high reset
//   in_valid/in_ready      operand stream handshake (in_ready = FIFO not full)
//   in_a, in_b             operand pair
//   gcd_enable             one-cycle launch pulse to the core
//   gcd_a, gcd_b           operands to the core, held from launch until gcd_valid
//   gcd_valid, gcd_y       core result
//   out_valid/out_ready    result stream handshake
//   out_a, out_b, out_y    returned operands and their gcd
//   fifo_count             pairs currently queued
//   busy                   FSM not idle or FIFO not empty
//
// Optional feature
//   GCD_DISPATCH_ZERO_BYPASS_EN
//     When defined, a head pair with a zero operand is answered directly
//     (out_y = a | b) without launching the core.
module gcd_dispatch #(
  parameter int DATA_WIDTH = 9,
  parameter int FIFO_DEPTH = 4,
  localparam int FIFO_AW = $clog2(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
  output logic                  gcd_enable,
  output logic [DATA_WIDTH-1:0] gcd_a,
  output logic [DATA_WIDTH-1:0] gcd_b,
  input  logic                  gcd_valid,
  input  logic [DATA_WIDTH-1:0] gcd_y,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_a,
  output logic [DATA_WIDTH-1:0] out_b,
  output logic [DATA_WIDTH-1:0] out_y,
  output logic [FIFO_AW:0]      fifo_count,
  output logic                  busy
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LAUNCH = 3'd1;
  localparam logic [2:0] S_ARM    = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam logic [FIFO_AW-1:0] PTR_ONE  = (FIFO_AW)'(1);
  localparam logic [FIFO_AW:0]   CNT_ONE  = (FIFO_AW+1)'(1);
  localparam logic [FIFO_AW:0]   CNT_FULL = (FIFO_AW+1)'(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem_a_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] mem_b_q [FIFO_DEPTH];
  logic [FIFO_AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]      count_q, count_d;
  logic                  full_q, empty_q;
  logic [2:0]            state_q, state_d;
  logic [DATA_WIDTH-1:0] gcd_a_q, gcd_b_q;
  logic [DATA_WIDTH-1:0] out_a_q, out_b_q, out_y_q;
  logic                  out_valid_q;

  logic                  push, pop, bypass;
  logic [DATA_WIDTH-1:0] head_a, head_b;

  assign head_a = mem_a_q[rd_ptr_q];
  assign head_b = mem_b_q[rd_ptr_q];

  // full/empty are registered, so a pair pushed this cycle is seen next cycle.
  assign push = in_valid && !full_q;
  assign pop  = (state_q == S_IDLE) && !empty_q;

`ifdef GCD_DISPATCH_ZERO_BYPASS_EN
  assign bypass = pop && ((head_a == '0) || (head_b == '0));
`else
  assign bypass = 1'b0;
`endif

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CNT_ONE;
    end else if (pop && !push) begin
      count_d = count_q - CNT_ONE;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (pop) state_d = bypass ? S_DONE : S_LAUNCH;
      S_LAUNCH: state_d = S_ARM;
      // ARM lets the core drop a result left over from the previous launch.
      S_ARM:    state_d = S_WAIT;
      S_WAIT:   if (gcd_valid) state_d = S_DONE;
      S_DONE:   if (out_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // FIFO storage: written only on accepted pushes, contents need no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_a_q[wr_ptr_q] <= in_a;
      mem_b_q[wr_ptr_q] <= in_b;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      state_q     <= S_IDLE;
      gcd_a_q     <= '0;
      gcd_b_q     <= '0;
      out_a_q     <= '0;
      out_b_q     <= '0;
      out_y_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
        gcd_a_q  <= head_a;
        gcd_b_q  <= head_b;
      end
      count_q <= count_d;
      full_q  <= (count_d == CNT_FULL);
      empty_q <= (count_d == '0);
      state_q <= state_d;

      if (bypass) begin
        // gcd(0,x) = x and gcd(0,0) = 0, which is exactly a | b here.
        out_a_q     <= head_a;
        out_b_q     <= head_b;
        out_y_q     <= head_a | head_b;
        out_valid_q <= 1'b1;
      end else if ((state_q == S_WAIT) && gcd_valid) begin
        out_a_q     <= gcd_a_q;
        out_b_q     <= gcd_b_q;
        out_y_q     <= gcd_y;
        out_valid_q <= 1'b1;
      end else if ((state_q == S_DONE) && out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign in_ready   = !full_q;
  assign gcd_enable = (state_q == S_LAUNCH);
  assign gcd_a      = gcd_a_q;
  assign gcd_b      = gcd_b_q;
  assign out_valid  = out_valid_q;
  assign out_a      = out_a_q;
  assign out_b      = out_b_q;
  assign out_y      = out_y_q;
  assign fifo_count = count_q;
  assign busy       = (state_q != S_IDLE) || !empty_q;

endmodule

// File: tb/tb_gcd_dispatch.sv
// Testbench for gcd_dispatch.
// The stimulus pushes the expected result of every accepted pair into a
// queue. A separate monitor pops that queue on each output handshake and
// compares. The gcd core is modelled inside the bench:
//   - the true result arrives 2..6 cycles after launch;
//   - a stale result may appear in the cycle right after launch;
//   - stray gcd_valid pulses may appear while nothing is in flight.
module tb_gcd_dispatch;

  localparam int DW    = 9;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  typedef struct packed {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] y;
  } pair_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid, in_ready;
  logic [DW-1:0] in_a, in_b;
  logic          gcd_enable;
  logic [DW-1:0] gcd_a, gcd_b;
  logic          gcd_valid;
  logic [DW-1:0] gcd_y;
  logic          out_valid, out_ready;
  logic [DW-1:0] out_a, out_b, out_y;
  logic [AW:0]   fifo_count;
  logic          busy;

  gcd_dispatch #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .gcd_enable(gcd_enable), .gcd_a(gcd_a), .gcd_b(gcd_b),
    .gcd_valid(gcd_valid), .gcd_y(gcd_y),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_y(out_y),
    .fifo_count(fifo_count), .busy(busy)
  );

  always #5 clk = ~clk;

  int    n_cmp    = 0;
  int    n_fail   = 0;
  int    n_en     = 0;
  int    n_exp_en = 0;
  pair_t sb_q[$];
  pair_t pend_q[$];

  function automatic int ref_gcd(input int a, input int b);
    int t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  function automatic bit is_launch(input logic [DW-1:0] a, input logic [DW-1:0] b);
`ifdef GCD_DISPATCH_ZERO_BYPASS_EN
    return (a != 0) && (b != 0);
`else
    return 1'b1;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic sb_push(input logic [DW-1:0] a, input logic [DW-1:0] b);
    pair_t p;
    p.a = a;
    p.b = b;
    p.y = DW'(ref_gcd(int'(a), int'(b)));
    sb_q.push_back(p);
  endtask

  function automatic pair_t mk(input int a, input int b);
    pair_t p;
    p   = '0;
    p.a = DW'(a);
    p.b = DW'(b);
    return p;
  endfunction

  function automatic pair_t rnd_pair();
    pair_t p;
    int    m;
    p   = '0;
    p.a = DW'($urandom);
    p.b = DW'($urandom);
    case ($urandom_range(0, 9))
      0: p.a = '0;
      1: p.b = '0;
      2: p.b = p.a;
      3: p.a = '1;
      4: begin
        m   = $urandom_range(2, 20);
        p.a = DW'(m * $urandom_range(0, 25));
        p.b = DW'(m * $urandom_range(0, 25));
      end
      default: ;
    endcase
    return p;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- gcd core model ----------------
  int            core_cnt = 0;
  bit            core_arm = 1'b0;
  logic [DW-1:0] core_y, cap_a, cap_b;

  initial begin
    forever begin
      @(posedge clk);
      #2;
      gcd_valid = 1'b0;
      gcd_y     = '0;
      if (reset) begin
        core_cnt = 0;
      end else if (core_cnt != 0) begin
        chk("enable_single_pulse", gcd_enable, 1'b0);
        core_cnt--;
        if (core_cnt == 0) begin
          chk("gcd_a_hold", gcd_a, cap_a);
          chk("gcd_b_hold", gcd_b, cap_b);
          gcd_valid = 1'b1;
          gcd_y     = core_y;
        end else if (core_arm) begin
          core_arm = 1'b0;
          if ($urandom_range(0, 1) == 1) begin
            gcd_valid = 1'b1;
            gcd_y     = ~core_y;
          end
        end
      end else if (gcd_enable) begin
        cap_a    = gcd_a;
        cap_b    = gcd_b;
        core_y   = DW'(ref_gcd(int'(gcd_a), int'(gcd_b)));
        core_cnt = $urandom_range(2, 6);
        core_arm = 1'b1;
        n_en++;
      end else if ($urandom_range(0, 3) == 0) begin
        gcd_valid = 1'b1;
        gcd_y     = DW'($urandom);
      end
    end
  end

  // ---------------- output monitor ----------------
  pair_t         mon_p;
  bit            hold_v = 1'b0;
  logic [DW-1:0] ha, hb, hy;

  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        hold_v = 1'b0;
      end else begin
        if (hold_v) begin
          chk("hold_valid", out_valid, 1'b1);
          chk("hold_out_y", out_y, hy);
          chk("hold_out_ab", {out_a, out_b}, {ha, hb});
        end
        if (out_valid && out_ready) begin
          if (sb_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_result: out_y=%0d with nothing expected", out_y);
          end else begin
            mon_p = sb_q.pop_front();
            chk("out_a", out_a, mon_p.a);
            chk("out_b", out_b, mon_p.b);
            chk("out_y", out_y, mon_p.y);
            if (is_launch(mon_p.a, mon_p.b)) n_exp_en++;
          end
          hold_v = 1'b0;
        end else if (out_valid) begin
          hold_v = 1'b1;
          ha     = out_a;
          hb     = out_b;
          hy     = out_y;
        end else begin
          hold_v = 1'b0;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic push_one(input int a, input int b, input logic rdy, input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      step();
      in_valid  = 1'b1;
      in_a      = DW'(a);
      in_b      = DW'(b);
      out_ready = rdy;
      @(negedge clk);
      if (in_ready) begin
        sb_push(DW'(a), DW'(b));
        done = 1'b1;
      end
    end
    if (!done) begin
      n_cmp++;
      n_fail++;
      $display("FAIL push_timeout: pair (%0d,%0d) not accepted in %0d cycles", a, b, budget);
    end
  endtask

  task automatic run_pairs(input int vld_pct, input int rdy_pct, input string tag);
    int    guard;
    bit    have;
    pair_t p;
    guard = 0;
    have  = 1'b0;
    p     = '0;
    while ((pend_q.size() != 0 || have || sb_q.size() != 0 || busy === 1'b1) && guard < 5000) begin
      if (!have && pend_q.size() != 0) begin
        p    = pend_q.pop_front();
        have = 1'b1;
      end
      step();
      in_valid  = have && ($urandom_range(1, 100) <= vld_pct);
      in_a      = p.a;
      in_b      = p.b;
      out_ready = ($urandom_range(1, 100) <= rdy_pct);
      @(negedge clk);
      if (in_valid && in_ready) begin
        sb_push(p.a, p.b);
        have = 1'b0;
      end
      guard++;
    end
    step();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    chk({tag, "_drain_timeout"}, guard >= 5000, 1'b0);
    chk({tag, "_scoreboard_empty"}, sb_q.size(), 0);
    chk({tag, "_enable_count"}, n_en, n_exp_en);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b0;
    gcd_valid = 1'b0;
    gcd_y     = '0;

    repeat (3) step();
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_fifo_count", fifo_count, 0);
    chk("rst_enable", gcd_enable, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_outs", {out_a, out_b, out_y, gcd_a, gcd_b}, '0);

    // Single pair
    pend_q.push_back(mk(49, 21));
    run_pairs(100, 100, "single");

    // Back-to-back list
    pend_q.push_back(mk(9, 27));
    pend_q.push_back(mk(49, 21));
    pend_q.push_back(mk(40, 40));
    pend_q.push_back(mk(250, 190));
    pend_q.push_back(mk(250, 5));
    run_pairs(100, 100, "list");

    // Backpressure: first result held, FIFO fills, 6th pair stalls
    push_one(9, 27, 1'b0, 10);
    push_one(49, 21, 1'b0, 10);
    push_one(40, 40, 1'b0, 10);
    push_one(250, 190, 1'b0, 10);
    push_one(250, 5, 1'b0, 10);
    step();
    in_valid = 1'b0;
    repeat (10) step();
    @(negedge clk);
    chk("bp_out_valid", out_valid, 1'b1);
    chk("bp_out_y", out_y, 9);
    chk("bp_fifo_count", fifo_count, 4);
    chk("bp_in_ready", in_ready, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step();
      in_valid = 1'b1;
      in_a     = DW'(12);
      in_b     = DW'(18);
    end
    @(negedge clk);
    chk("bp_stall_in_ready", in_ready, 1'b0);
    chk("bp_stall_count", fifo_count, 4);
    push_one(12, 18, 1'b1, 40);
    run_pairs(100, 100, "bp");

    // Push and pop in the same cycle at fifo_count = 3
    push_one(30, 12, 1'b0, 10);
    push_one(14, 21, 1'b0, 10);
    push_one(100, 75, 1'b0, 10);
    push_one(81, 54, 1'b0, 10);
    step();
    in_valid = 1'b0;
    repeat (10) step();
    @(negedge clk);
    chk("pp_pre_count", fifo_count, 3);
    chk("pp_pre_valid", out_valid, 1'b1);
    step();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_a      = DW'(64);
    in_b      = DW'(48);
    @(negedge clk);
    chk("pp_in_ready_push", in_ready, 1'b1);
    if (in_ready) sb_push(DW'(64), DW'(48));
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("pp_fifo_count", fifo_count, 3);
    chk("pp_in_ready", in_ready, 1'b1);
    run_pairs(100, 70, "pushpop");

    // Zero operand
    push_one(0, 12, 1'b0, 10);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("zero_no_enable_early", gcd_enable, 1'b0);
    step();
    @(negedge clk);
`ifdef GCD_DISPATCH_ZERO_BYPASS_EN
    chk("zero_bypass_valid", out_valid, 1'b1);
    chk("zero_bypass_y", out_y, 12);
    chk("zero_bypass_enable", gcd_enable, 1'b0);
`else
    chk("zero_launch_enable", gcd_enable, 1'b1);
    chk("zero_launch_a", gcd_a, 0);
    chk("zero_launch_b", gcd_b, 12);
`endif
    run_pairs(100, 100, "zero");

    // Reset while the FSM waits on the core
    push_one(49, 21, 1'b1, 10);
    push_one(9, 27, 1'b1, 10);
    push_one(40, 40, 1'b1, 10);
    chk("launch_latency", gcd_enable, 1'b1);
    step();
    in_valid = 1'b0;
    step();
    reset = 1'b1;
    sb_q.delete();
    step();
    reset = 1'b0;
    n_en     = 0;
    n_exp_en = 0;
    @(negedge clk);
    chk("mid_rst_out_valid", out_valid, 1'b0);
    chk("mid_rst_fifo_count", fifo_count, 0);
    chk("mid_rst_enable", gcd_enable, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_in_ready", in_ready, 1'b1);
    pend_q.push_back(mk(49, 21));
    run_pairs(100, 100, "after_reset");

    // Randomized traffic
    for (int i = 0; i < 60; i++) pend_q.push_back(rnd_pair());
    run_pairs(70, 60, "rand_mixed");
    for (int i = 0; i < 30; i++) pend_q.push_back(rnd_pair());
    run_pairs(100, 100, "rand_full_rate");
    for (int i = 0; i < 30; i++) pend_q.push_back(rnd_pair());
    run_pairs(100, 20, "rand_backpressure");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete (compared %0d)", n_cmp);
    $fatal(1, "watchdog expired");
  end

endmodule
